// File: rtl/regfile_wb_queue_pkg.sv
// Shared widths and the queue entry type for the register file writeback queue.
package regfile_wb_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  typedef struct packed {
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_queue_if.sv
// Bundle of the writeback, register-file-port and decode-lookup signals around the queue.
// The master side is whoever drives requests and lookups; the slave side is the queue.
interface regfile_wb_queue_if #(
  parameter int DEPTH = 4
);
  import regfile_wb_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [RA_W-1:0]  in_rd;
  logic [XLEN-1:0]  in_data;

  logic             rf_ready;
  logic             rf_we;
  logic [RA_W-1:0]  rf_wn;
  logic [XLEN-1:0]  rf_data;

  logic [RA_W-1:0]  rs1;
  logic [RA_W-1:0]  rs2;
  logic             hit1;
  logic             hit2;
  logic [XLEN-1:0]  fwd1;
  logic [XLEN-1:0]  fwd2;

  logic [CNT_W-1:0] count;

  modport master (
    output in_valid, in_rd, in_data, rf_ready, rs1, rs2,
    input  in_ready, rf_we, rf_wn, rf_data, hit1, hit2, fwd1, fwd2, count
  );

  modport slave (
    input  in_valid, in_rd, in_data, rf_ready, rs1, rs2,
    output in_ready, rf_we, rf_wn, rf_data, hit1, hit2, fwd1, fwd2, count
  );

endinterface

// File: rtl/regfile_wb_queue_lookup.sv
// Forwarding search: finds the youngest valid queue entry whose rd matches the
// requested register. x0 never hits because it is never a real pending write.
module wb_lookup
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_entry_t [DEPTH-1:0]        entries,
  input  logic      [DEPTH-1:0]        valid,
  input  logic      [$clog2(DEPTH)-1:0] rd_ptr,
  input  logic      [RA_W-1:0]         rs,
  output logic                         hit,
  output logic      [XLEN-1:0]         fwd
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx;

  // Walk oldest to newest from the head so a later (younger) match overrides an earlier one.
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    idx = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((rs != '0) && valid[idx] && (entries[idx].rd == rs)) begin
        hit = 1'b1;
        fwd = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// Writeback queue in front of the register file write port. Retiring results are
// buffered and drained in order, one per cycle while the write port is free, and
// decode can look up pending values through two forwarding ports.
module regfile_wb_queue
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  regfile_wb_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t [DEPTH-1:0] entries;
  logic      [DEPTH-1:0] valid;
  logic      [PTR_W-1:0] rd_ptr;
  logic      [PTR_W-1:0] wr_ptr;
  logic      [CNT_W-1:0] count_q;

  logic full;
  logic empty;
  logic push;
  logic store;
  logic pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // in_ready depends only on registered occupancy, so a pop never opens a slot in the same cycle.
  assign push  = bus.in_valid && !full;
  assign store = push && (bus.in_rd != '0);
  assign pop   = !empty && bus.rf_ready;

  assign bus.in_ready = !full;
  assign bus.rf_we    = pop;
  assign bus.rf_wn    = empty ? '0 : entries[rd_ptr].rd;
  assign bus.rf_data  = empty ? '0 : entries[rd_ptr].data;
  assign bus.count    = count_q;

  // Pointers, occupancy and valid bits; reset discards anything still pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      valid   <= '0;
    end else begin
      if (store) begin
        wr_ptr        <= wr_ptr + PTR_W'(1);
        valid[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr        <= rd_ptr + PTR_W'(1);
        valid[rd_ptr] <= 1'b0;
      end
      case ({store, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry payload storage; contents are only meaningful where the valid bit is set.
  always_ff @(posedge clk) begin
    if (store) begin
      entries[wr_ptr] <= '{rd: bus.in_rd, data: bus.in_data};
    end
  end

  wb_lookup #(.DEPTH(DEPTH)) u_lookup1 (
    .entries (entries),
    .valid   (valid),
    .rd_ptr  (rd_ptr),
    .rs      (bus.rs1),
    .hit     (bus.hit1),
    .fwd     (bus.fwd1)
  );

  wb_lookup #(.DEPTH(DEPTH)) u_lookup2 (
    .entries (entries),
    .valid   (valid),
    .rd_ptr  (rd_ptr),
    .rs      (bus.rs2),
    .hit     (bus.hit2),
    .fwd     (bus.fwd2)
  );

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Testbench for regfile_wb_queue: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_regfile_wb_queue;

  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  regfile_wb_queue_if #(.DEPTH(DEPTH)) bus ();

  regfile_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file stand-in: captures on the negedge preceding the pop edge, x0 stays zero.
  logic [31:0] regs [32] = '{default: 32'h0};
  always @(negedge clk) begin
    if (rst_n && bus.rf_we && (bus.rf_wn != 5'd0))
      regs[bus.rf_wn] <= bus.rf_data;
  end

  typedef struct {
    logic        in_valid;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic        rf_ready;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        e_ready;
    logic        e_we;
    logic [4:0]  e_wn;
    logic [31:0] e_data;
    logic        e_hit1;
    logic [31:0] e_fwd1;
    logic        e_hit2;
    logic [31:0] e_fwd2;
    logic [2:0]  e_count;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t model_q[$];

  task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic [31:0] d,
                               input logic rr, input logic [4:0] a1, input logic [4:0] a2);
    bus.in_valid = v;
    bus.in_rd    = rd;
    bus.in_data  = d;
    bus.rf_ready = rr;
    bus.rs1      = a1;
    bus.rs2      = a2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void modelLookup(input logic [4:0] rs, output logic hit, output logic [31:0] fwd);
    hit = 1'b0;
    fwd = 32'h0;
    if (rs != 5'd0) begin
      for (int k = model_q.size() - 1; k >= 0; k--) begin
        if (model_q[k].rd == rs) begin
          hit = 1'b1;
          fwd = model_q[k].data;
          break;
        end
      end
    end
  endfunction

  vec_t vecs [10];

  initial begin
    logic        m_ready, m_we, m_hit1, m_hit2;
    logic [4:0]  m_wn;
    logic [31:0] m_data, m_fwd1, m_fwd2;
    int          thr;

    rst_n = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);

    vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 3'd0};
    vecs[1] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 3'd1};
    vecs[2] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 3'd0};
    vecs[3] = '{1'b1, 5'd7, 32'h1, 1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 3'd0};
    vecs[4] = '{1'b1, 5'd7, 32'h2, 1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 32'h1, 1'b1, 32'h1, 1'b0, 32'h0, 3'd1};
    vecs[5] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd7, 1'b1, 1'b0, 5'd7, 32'h1, 1'b1, 32'h2, 1'b1, 32'h2, 3'd2};
    vecs[6] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd3, 1'b1, 1'b1, 5'd7, 32'h1, 1'b1, 32'h2, 1'b0, 32'h0, 3'd2};
    vecs[7] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0, 1'b1, 1'b1, 5'd7, 32'h2, 1'b1, 32'h2, 1'b0, 32'h0, 3'd1};
    vecs[8] = '{1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 3'd0};
    vecs[9] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 3'd0};

    // Reset state while held in reset.
    @(negedge clk);
    checkOutput("reset.count", 32'(bus.count), 32'd0);
    checkOutput("reset.in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("reset.rf_we", 32'(bus.rf_we), 32'd0);
    checkOutput("reset.hit1", 32'(bus.hit1), 32'd0);
    #1 rst_n = 1'b1;
    tick();

    // Vector table: single push/drain, same-rd ordering with forwarding, and x0 pushes.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].in_valid, vecs[i].in_rd, vecs[i].in_data, vecs[i].rf_ready, vecs[i].rs1, vecs[i].rs2);
      @(negedge clk);
      checkOutput($sformatf("vec%0d.in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_ready));
      checkOutput($sformatf("vec%0d.rf_we", i), 32'(bus.rf_we), 32'(vecs[i].e_we));
      checkOutput($sformatf("vec%0d.rf_wn", i), 32'(bus.rf_wn), 32'(vecs[i].e_wn));
      checkOutput($sformatf("vec%0d.rf_data", i), bus.rf_data, vecs[i].e_data);
      checkOutput($sformatf("vec%0d.hit1", i), 32'(bus.hit1), 32'(vecs[i].e_hit1));
      checkOutput($sformatf("vec%0d.fwd1", i), bus.fwd1, vecs[i].e_fwd1);
      checkOutput($sformatf("vec%0d.hit2", i), 32'(bus.hit2), 32'(vecs[i].e_hit2));
      checkOutput($sformatf("vec%0d.fwd2", i), bus.fwd2, vecs[i].e_fwd2);
      checkOutput($sformatf("vec%0d.count", i), 32'(bus.count), 32'(vecs[i].e_count));
      tick();
    end
    checkOutput("regfile.x5", regs[5], 32'hDEADBEEF);
    checkOutput("regfile.x7", regs[7], 32'h2);
    checkOutput("regfile.x0", regs[0], 32'h0);

    // Fill while the write port is busy, refuse a fifth push, then drain with in_valid held.
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 5'(k), 32'h100 + 32'(k), 1'b0, 5'd0, 5'd0);
      tick();
    end
    applyStimulus(1'b1, 5'd9, 32'h999, 1'b0, 5'd9, 5'd3);
    @(negedge clk);
    checkOutput("full.in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("full.count", 32'(bus.count), 32'd4);
    checkOutput("full.rf_we", 32'(bus.rf_we), 32'd0);
    checkOutput("full.hit1", 32'(bus.hit1), 32'd0);
    checkOutput("full.fwd2", bus.fwd2, 32'h103);
    tick();
    @(negedge clk);
    checkOutput("refused.count", 32'(bus.count), 32'd4);
    tick();
    applyStimulus(1'b1, 5'd9, 32'h999, 1'b1, 5'd9, 5'd0);
    @(negedge clk);
    checkOutput("drain0.rf_we", 32'(bus.rf_we), 32'd1);
    checkOutput("drain0.rf_wn", 32'(bus.rf_wn), 32'd1);
    checkOutput("drain0.rf_data", bus.rf_data, 32'h101);
    checkOutput("drain0.in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("drain1.count", 32'(bus.count), 32'd3);
    checkOutput("drain1.in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("drain1.rf_wn", 32'(bus.rf_wn), 32'd2);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0);
    @(negedge clk);
    checkOutput("drain2.count", 32'(bus.count), 32'd3);
    checkOutput("drain2.rf_wn", 32'(bus.rf_wn), 32'd3);
    checkOutput("drain2.hit1", 32'(bus.hit1), 32'd1);
    tick();
    @(negedge clk);
    checkOutput("drain3.rf_wn", 32'(bus.rf_wn), 32'd4);
    tick();
    @(negedge clk);
    checkOutput("drain4.rf_wn", 32'(bus.rf_wn), 32'd9);
    checkOutput("drain4.rf_data", bus.rf_data, 32'h999);
    tick();
    @(negedge clk);
    checkOutput("drained.rf_we", 32'(bus.rf_we), 32'd0);
    checkOutput("drained.count", 32'(bus.count), 32'd0);
    tick();
    for (int k = 1; k <= 4; k++)
      checkOutput($sformatf("regfile.x%0d", k), regs[k], 32'h100 + 32'(k));
    checkOutput("regfile.x9", regs[9], 32'h999);

    // Asynchronous reset with three entries pending: everything is dropped at once.
    for (int k = 10; k <= 12; k++) begin
      applyStimulus(1'b1, 5'(k), 32'h200 + 32'(k), 1'b0, 5'd0, 5'd0);
      tick();
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd10, 5'd0);
    checkOutput("prerst.count", 32'(bus.count), 32'd3);
    #2;
    bus.rf_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst.count", 32'(bus.count), 32'd0);
    checkOutput("rst.rf_we", 32'(bus.rf_we), 32'd0);
    checkOutput("rst.hit1", 32'(bus.hit1), 32'd0);
    checkOutput("rst.in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("postrst.rf_we", 32'(bus.rf_we), 32'd0);
    checkOutput("regfile.x10", regs[10], 32'h0);
    tick();

    // Randomized traffic against the queue model, with rf_ready duty varied to fill and drain.
    model_q.delete();
    for (int c = 0; c < 600; c++) begin
      thr = (c / 50) % 3 == 0 ? 20 : ((c / 50) % 3 == 1 ? 55 : 90);
      applyStimulus(($urandom_range(0, 99) < 70), 5'($urandom_range(0, 7)), $urandom,
                    ($urandom_range(0, 99) < thr), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      @(negedge clk);
      m_ready = (model_q.size() < DEPTH);
      m_we    = (model_q.size() > 0) && bus.rf_ready;
      m_wn    = (model_q.size() > 0) ? model_q[0].rd : 5'd0;
      m_data  = (model_q.size() > 0) ? model_q[0].data : 32'h0;
      modelLookup(bus.rs1, m_hit1, m_fwd1);
      modelLookup(bus.rs2, m_hit2, m_fwd2);
      checkOutput($sformatf("rnd%0d.in_ready", c), 32'(bus.in_ready), 32'(m_ready));
      checkOutput($sformatf("rnd%0d.rf_we", c), 32'(bus.rf_we), 32'(m_we));
      checkOutput($sformatf("rnd%0d.rf_wn", c), 32'(bus.rf_wn), 32'(m_wn));
      checkOutput($sformatf("rnd%0d.rf_data", c), bus.rf_data, m_data);
      checkOutput($sformatf("rnd%0d.hit1", c), 32'(bus.hit1), 32'(m_hit1));
      checkOutput($sformatf("rnd%0d.fwd1", c), bus.fwd1, m_fwd1);
      checkOutput($sformatf("rnd%0d.hit2", c), 32'(bus.hit2), 32'(m_hit2));
      checkOutput($sformatf("rnd%0d.fwd2", c), bus.fwd2, m_fwd2);
      checkOutput($sformatf("rnd%0d.count", c), 32'(bus.count), 32'(model_q.size()));
      @(posedge clk);
      if (m_we)
        void'(model_q.pop_front());
      if (bus.in_valid && m_ready && (bus.in_rd != 5'd0))
        model_q.push_back('{rd: bus.in_rd, data: bus.in_data});
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
